// File: rtl/resonator_ddc_axis_stall_monitor_if.sv
// resonator_ddc_axis_stall_monitor_if: per-channel block inputs and stall status outputs of the stall monitor.
// Optional sticky/first-event ports exist only when STALL_STICKY_EN is defined.
interface resonator_ddc_axis_stall_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0]   axis_block_sigs;
  logic [CNT_W-1:0]    threshold;
  logic [2*NUM_CH-1:0] axis_block_info;
  logic                block;
  logic [CNT_W-1:0]    stall_cnt_max;
`ifdef STALL_STICKY_EN
  logic                clear;
  logic [NUM_CH-1:0]   sticky_mask;
  logic                first_valid;
  logic [CH_W-1:0]     first_ch;
  modport master (
    output axis_block_sigs, threshold, clear,
    input  axis_block_info, block, stall_cnt_max, sticky_mask, first_valid, first_ch
  );
  modport slave (
    input  axis_block_sigs, threshold, clear,
    output axis_block_info, block, stall_cnt_max, sticky_mask, first_valid, first_ch
  );
`else
  modport master (
    output axis_block_sigs, threshold,
    input  axis_block_info, block, stall_cnt_max
  );
  modport slave (
    input  axis_block_sigs, threshold,
    output axis_block_info, block, stall_cnt_max
  );
`endif
endinterface

// File: rtl/resonator_ddc_axis_stall_monitor.sv
// resonator_ddc_axis_stall_monitor: flags AXIS channels blocked for more than threshold consecutive cycles.
// Define STALL_STICKY_EN to add sticky stall mask and first-stalled-channel capture.
module resonator_ddc_axis_stall_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic clock,
  input  logic reset,
  resonator_ddc_axis_stall_monitor_if.slave mon
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, inc;
  logic [NUM_CH-1:0]            stalled_q, stalled_d;
  logic [2*NUM_CH-1:0]          info_q, info_d;
  logic [CNT_W-1:0]             max_q, max_d;
  always_comb begin
    inc       = '0;
    cnt_d     = '0;
    stalled_d = '0;
    info_d    = '0;
    max_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i]         = &cnt_q[i] ? cnt_q[i] : cnt_q[i] + 1'b1;
      cnt_d[i]       = mon.axis_block_sigs[i] ? inc[i] : '0;
      stalled_d[i]   = mon.axis_block_sigs[i] && (inc[i] > mon.threshold);
      info_d[2*i+:2] = stalled_d[i] ? ((i % 2) != 0 ? 2'b01 : 2'b10) : 2'b00;
      max_d          = cnt_q[i] > max_d ? cnt_q[i] : max_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      stalled_q <= '0;
      info_q    <= '0;
      max_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      stalled_q <= stalled_d;
      info_q    <= info_d;
      max_q     <= max_d;
    end
  end
  assign mon.axis_block_info = info_q;
  assign mon.block           = |stalled_q;
  assign mon.stall_cnt_max   = max_q;
`ifdef STALL_STICKY_EN
  logic [NUM_CH-1:0] sticky_mask_q, sticky_mask_d;
  logic              first_valid_q, first_valid_d;
  logic [CH_W-1:0]   first_ch_q, first_ch_d, low_ch;
  // A flag arriving with clear wins, so it becomes the new first event.
  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) low_ch = stalled_d[i] ? CH_W'(i) : low_ch;
    sticky_mask_d = (mon.clear ? '0 : sticky_mask_q) | stalled_d;
    first_valid_d = (mon.clear ? 1'b0 : first_valid_q) | (|stalled_d);
    first_ch_d    = ((|stalled_d) && (mon.clear || !first_valid_q)) ? low_ch : first_ch_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_mask_q <= '0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
    end else begin
      sticky_mask_q <= sticky_mask_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
    end
  end
  assign mon.sticky_mask = sticky_mask_q;
  assign mon.first_valid = first_valid_q;
  assign mon.first_ch    = first_ch_q;
`endif
endmodule

// File: tb/tb_resonator_ddc_axis_stall_monitor.sv
// tb_resonator_ddc_axis_stall_monitor: directed vectors queued with hand-computed outputs, checked by a separate monitor.
module tb_resonator_ddc_axis_stall_monitor;
  localparam int NCH = 4;
  localparam int CW  = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  resonator_ddc_axis_stall_monitor_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();
  resonator_ddc_axis_stall_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .mon  (bus)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic       b;
    logic [7:0] info;
    logic [3:0] mx;
    logic       sk;
    logic [3:0] sm;
    logic       fv;
    logic [1:0] fc;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad   = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, req, $time);
    end
  endtask
  // One cycle of stimulus; the expected values are what the outputs read after the following edge.
  task automatic v(input logic r, input logic [3:0] s, input logic [3:0] t, input logic c,
                   input logic b, input logic [7:0] info, input logic [3:0] mx,
                   input logic sk = 1'b0, input logic [3:0] sm = 4'h0, input logic fv = 1'b0,
                   input logic [1:0] fc = 2'd0);
    exp_t e;
    @(negedge clock);
    reset = r;
    bus.axis_block_sigs = s;
    bus.threshold = t;
`ifdef STALL_STICKY_EN
    bus.clear = c;
`else
    if (c) $display("note: clear ignored without sticky feature");
`endif
    e = '{b, info, mx, sk, sm, fv, fc};
    q.push_back(e);
  endtask
  initial begin
    forever begin
      exp_t e;
      @(posedge clock);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("block", 32'(bus.block), 32'(e.b));
        chk("info", 32'(bus.axis_block_info), 32'(e.info));
        chk("cnt_max", 32'(bus.stall_cnt_max), 32'(e.mx));
`ifdef STALL_STICKY_EN
        if (e.sk) begin
          chk("sticky_mask", 32'(bus.sticky_mask), 32'(e.sm));
          chk("first_valid", 32'(bus.first_valid), 32'(e.fv));
          chk("first_ch", 32'(bus.first_ch), 32'(e.fc));
        end
`endif
      end
    end
  end
  initial begin
    bus.axis_block_sigs = '0;
    bus.threshold = '0;
`ifdef STALL_STICKY_EN
    bus.clear = 1'b0;
`endif
    v(1, 4'b0000, 0, 0, 0, 8'h00, 0, 1, 4'h0, 0, 0);
    v(1, 4'b0000, 0, 0, 0, 8'h00, 0, 1, 4'h0, 0, 0);
    // threshold 0: one blocked cycle on ch0 flags on the very next edge
    v(0, 4'b0001, 0, 0, 1, 8'h02, 0);
    v(0, 4'b0000, 0, 0, 0, 8'h00, 1);
    v(0, 4'b0000, 0, 0, 0, 8'h00, 0);
    // threshold 3 on ch1: 3 cycles no flag, 4 cycles flags
    v(0, 4'b0010, 3, 0, 0, 8'h00, 0);
    v(0, 4'b0010, 3, 0, 0, 8'h00, 1);
    v(0, 4'b0010, 3, 0, 0, 8'h00, 2);
    v(0, 4'b0000, 3, 0, 0, 8'h00, 3);
    v(0, 4'b0000, 3, 0, 0, 8'h00, 0);
    v(0, 4'b0010, 3, 0, 0, 8'h00, 0);
    v(0, 4'b0010, 3, 0, 0, 8'h00, 1);
    v(0, 4'b0010, 3, 0, 0, 8'h00, 2);
    v(0, 4'b0010, 3, 0, 1, 8'h04, 3);
    v(0, 4'b0000, 3, 0, 0, 8'h00, 4);
    v(0, 4'b0000, 3, 0, 0, 8'h00, 0);
    // threshold 2 on ch2: pattern 1,1,0,1,1,1
    v(0, 4'b0100, 2, 0, 0, 8'h00, 0);
    v(0, 4'b0100, 2, 0, 0, 8'h00, 1);
    v(0, 4'b0000, 2, 0, 0, 8'h00, 2);
    v(0, 4'b0100, 2, 0, 0, 8'h00, 0);
    v(0, 4'b0100, 2, 0, 0, 8'h00, 1);
    v(0, 4'b0100, 2, 0, 1, 8'h20, 2);
    v(0, 4'b0000, 2, 0, 0, 8'h00, 3);
    v(0, 4'b0000, 2, 0, 0, 8'h00, 0);
    // ch0+ch3 blocked, threshold 5, reset mid-stall
    v(0, 4'b1001, 5, 0, 0, 8'h00, 0);
    v(0, 4'b1001, 5, 0, 0, 8'h00, 1);
    v(0, 4'b1001, 5, 0, 0, 8'h00, 2);
    v(0, 4'b1001, 5, 0, 0, 8'h00, 3);
    v(1, 4'b1001, 5, 0, 0, 8'h00, 0);
    v(0, 4'b1001, 5, 0, 0, 8'h00, 0);
    v(0, 4'b1001, 5, 0, 0, 8'h00, 1);
    v(0, 4'b1001, 5, 0, 0, 8'h00, 2);
    v(0, 4'b1001, 5, 0, 0, 8'h00, 3);
    v(0, 4'b1001, 5, 0, 0, 8'h00, 4);
    v(0, 4'b1001, 5, 0, 1, 8'h42, 5);
    v(0, 4'b1001, 5, 0, 1, 8'h42, 6);
    // threshold raised above count clears, lowered below count re-flags
    v(0, 4'b1001, 10, 0, 0, 8'h00, 7);
    v(0, 4'b1001, 3, 0, 1, 8'h42, 8);
    v(0, 4'b0000, 3, 0, 0, 8'h00, 9);
    v(0, 4'b0000, 3, 0, 0, 8'h00, 0);
    // saturation: threshold 15 never flags with a 4-bit counter
    for (int k = 1; k <= 40; k++) v(0, 4'b0001, 15, 0, 0, 8'h00, (k - 1) < 15 ? 4'(k - 1) : 4'hf);
    v(0, 4'b0001, 14, 0, 1, 8'h02, 15);
    v(0, 4'b0001, 14, 0, 1, 8'h02, 15);
    v(0, 4'b0000, 14, 0, 0, 8'h00, 15);
    v(0, 4'b0000, 14, 0, 0, 8'h00, 0);
`ifdef STALL_STICKY_EN
    v(1, 4'b0000, 0, 0, 0, 8'h00, 0, 1, 4'h0, 0, 0);
    v(0, 4'b0110, 0, 0, 1, 8'h24, 0, 1, 4'b0110, 1, 1);
    v(0, 4'b0000, 0, 0, 0, 8'h00, 1, 1, 4'b0110, 1, 1);
    v(0, 4'b1000, 0, 1, 1, 8'h40, 0, 1, 4'b1000, 1, 3);
    v(0, 4'b0000, 0, 0, 0, 8'h00, 1, 1, 4'b1000, 1, 3);
    v(0, 4'b0000, 0, 1, 0, 8'h00, 0, 1, 4'b0000, 0, 3);
    v(0, 4'b0000, 0, 0, 0, 8'h00, 0, 1, 4'b0000, 0, 3);
`endif
    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clock);
    @(posedge clock);
    #3;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/resonator_ddc_axis_stall_monitor.md
Name: resonator_ddc_axis_stall_monitor

Overview:
Parametrised AXI-Stream deadlock/stall monitor for the resonator DDC dataflow instances. Watches NUM_CH per-channel AXIS block signals, each high while its channel is stalled, and flags a channel only after it has stayed blocked for a programmable number of consecutive cycles. Drives a per-channel 2-bit info field and an aggregate block flag. Sits beside the DDC top-level instance and feeds the co-simulation deadlock reporter and the debug status registers.

Parameters:
NUM_CH, 4, number of monitored AXIS channels (1..32).
CNT_W, 16, width of each per-channel persistence counter and of the threshold input.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
axis_block_sigs  input  NUM_CH  bit i high = channel i blocked this cycle.
threshold  input  CNT_W  extra consecutive blocked cycles needed before flagging; sampled every cycle.
axis_block_info  output  2*NUM_CH  per-channel stall code; bits [2i+1:2i] belong to channel i.
block  output  1  OR of all current per-channel stall flags.
stall_cnt_max  output  CNT_W  largest per-channel counter value in the current cycle (debug).

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock.
- Reset: all counters, stall flags, axis_block_info, block and stall_cnt_max go to 0.
- Per-channel counter cnt_i, registered, saturates at 2^CNT_W-1:
  - axis_block_sigs[i]=1: cnt_i <= sat(cnt_i+1).
  - axis_block_sigs[i]=0: cnt_i <= 0.
- Per-channel stall flag stalled_i, registered: stalled_i <= axis_block_sigs[i] && (sat(cnt_i+1) > threshold).
  - threshold=0 gives 1-cycle latency: flag rises on the edge that samples the first blocked cycle.
  - threshold=T needs T+1 consecutive blocked cycles. The flag rises on the edge that samples the (T+1)th one.
  - The flag drops on the edge that samples the first unblocked cycle. Any single-cycle gap restarts counting from 0.
- Info encoding, registered alongside stalled_i:
  - axis_block_info[2i+1:2i] = stalled_i ? ~(2'b01 << (i%2)) : 2'b00.
  - Channel 0 reports 2'b10, channel 1 reports 2'b01, and the pattern alternates for higher channels.
  - Every field reads 0 whenever block=0.
- block: combinational OR of all stalled_i. It is therefore aligned with axis_block_info and needs no extra register.
- stall_cnt_max: registered max over the cnt_i values (pre-update). On a tie the value is the same, so the source channel is irrelevant.
- Threshold change mid-stall: the new value applies immediately on the next compare. Lowering the threshold below the current cnt_i flags the channel on the next edge. Raising it above cnt_i clears the flag on the next edge.
- Counter saturation: cnt_i holds at all-ones, and with threshold < all-ones the flag stays asserted.
- Reset mid-stall: reset overrides everything. After reset, counting restarts from 0 even if the channel is still blocked.

Optional Feature:
STALL_STICKY_EN.
- Defined: adds input clear (1 bit) and outputs sticky_mask (NUM_CH bits), first_valid (1 bit) and first_ch (clog2(NUM_CH), min 1 bit).
  - sticky_mask[i] sets on any cycle stalled_i is set and holds until clear.
  - On the first flag after reset or clear, first_valid <= 1 and first_ch <= index of the flagged channel. The lowest index wins if several flag in the same cycle.
  - clear=1 zeroes sticky_mask and first_valid on the next edge. If a channel flags in the same cycle as clear, the set wins and is recorded as the new first event.
  - Reset zeroes all sticky state.
- Undefined: these ports and registers do not exist, and the core behaviour is unchanged.

Test Plan:
1. NUM_CH=4, threshold=0; drive axis_block_sigs=4'b0001 for 1 cycle -> next edge block=1, axis_block_info=8'h02; the following edge (sigs=0) block=0, info=0.
2. threshold=3; hold ch1 blocked 3 cycles, then release -> no flag. Hold ch1 blocked 4 cycles -> block=1 and info[3:2]=2'b01 starting the edge after the 4th blocked cycle.
3. threshold=2; ch2 blocked for pattern 1,1,0,1,1,1 -> flag only after the final three-cycle run, proving the gap restarts counting. stall_cnt_max reads 2 then 0, then climbs 1,2.
4. ch0 and ch3 blocked continuously, threshold=5; assert reset at cycle 4 for 1 cycle -> all outputs 0 on the reset edge; flags reappear 6 edges after reset deassertion.
5. STALL_STICKY_EN: ch2 and ch1 flag in the same cycle -> first_ch=1, sticky_mask=4'b0110. Assert clear while ch3 flags -> sticky_mask=4'b1000, first_ch=3, first_valid=1.
6. CNT_W=4, threshold=15, ch0 blocked 40 cycles -> cnt saturates at 15 and stall_cnt_max=15; the flag never asserts, because 15 > 15 is false.
